// File: rtl/wb_burst_master_if.sv
// Wishbone classic bus bundle for wb_burst_master.
// ERR_I exists only when WB_BURST_MASTER_ERR_EN is defined.
interface wb_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   ADR_O;
    logic [DATA_W-1:0]   DAT_O;
    logic [DATA_W-1:0]   DAT_I;
    logic                WE_O;
    logic [DATA_W/8-1:0] SEL_O;
    logic                STB_O;
    logic                CYC_O;
    logic                ACK_I;
`ifdef WB_BURST_MASTER_ERR_EN
    logic                ERR_I;

    modport master (
        output ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
        input  DAT_I, ACK_I, ERR_I
    );
    modport slave (
        input  ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
        output DAT_I, ACK_I, ERR_I
    );
`else
    modport master (
        output ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
        input  DAT_I, ACK_I
    );
    modport slave (
        input  ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
        output DAT_I, ACK_I
    );
`endif
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle burst master: command/data stream to single or incrementing bursts.
// Define WB_BURST_MASTER_ERR_EN to honour ERR_I (status 2'b10).
module wb_burst_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W/8-1:0] cmd_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic [1:0]          status,
    wb_burst_master_if.master   wb
);
    localparam int SEL_W = DATA_W / 8;
    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WDATA, REQ, GAP} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat;
    logic             we_q;
    logic [15:0]      tcnt;
    logic             err_in;

`ifdef WB_BURST_MASTER_ERR_EN
    assign err_in = wb.ERR_I;
`else
    assign err_in = 1'b0;
`endif

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            status    <= '0;
            wb.ADR_O  <= '0;
            wb.DAT_O  <= '0;
            wb.WE_O   <= 1'b0;
            wb.SEL_O  <= '0;
            wb.STB_O  <= 1'b0;
            wb.CYC_O  <= 1'b0;
            len_q     <= '0;
            beat      <= '0;
            we_q      <= 1'b0;
            tcnt      <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        we_q      <= cmd_we;
                        len_q     <= cmd_len;
                        beat      <= '0;
                        tcnt      <= '0;
                        wb.ADR_O  <= cmd_addr;
                        wb.SEL_O  <= cmd_sel;
                        wb.WE_O   <= cmd_we;
                        wb.CYC_O  <= 1'b1;
                        if (cmd_we) begin
                            wr_ready <= 1'b1;
                            state    <= WDATA;
                        end else begin
                            wb.STB_O <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                WDATA: begin
                    if (wr_valid) begin
                        wb.DAT_O <= wr_data;
                        wr_ready <= 1'b0;
                        wb.STB_O <= 1'b1;
                        tcnt     <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Priority: ACK over ERR over timeout expiry.
                    if (wb.ACK_I) begin
                        wb.STB_O <= 1'b0;
                        if (!we_q) begin
                            rd_data  <= wb.DAT_I;
                            rd_valid <= 1'b1;
                        end
                        if (beat == len_q) begin
                            wb.CYC_O  <= 1'b0;
                            wb.WE_O   <= 1'b0;
                            done      <= 1'b1;
                            status    <= 2'b00;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wb.ADR_O <= wb.ADR_O + ADDR_W'(SEL_W);
                            beat     <= beat + 1'b1;
                            state    <= GAP;
                        end
                    end else if (err_in) begin
                        wb.STB_O  <= 1'b0;
                        wb.CYC_O  <= 1'b0;
                        wb.WE_O   <= 1'b0;
                        done      <= 1'b1;
                        status    <= 2'b10;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (tcnt == TMAX) begin
                        wb.STB_O  <= 1'b0;
                        wb.CYC_O  <= 1'b0;
                        wb.WE_O   <= 1'b0;
                        done      <= 1'b1;
                        status    <= 2'b01;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                GAP: begin
                    tcnt <= '0;
                    if (we_q) begin
                        wr_ready <= 1'b1;
                        state    <= WDATA;
                    end else begin
                        wb.STB_O <= 1'b1;
                        state    <= REQ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: main DUT (32-bit address, TIMEOUT=8) plus an 8-bit-address DUT for wrap.
// Build with WB_BURST_MASTER_ERR_EN defined to include the bus-error case.
module tb_wb_burst_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- main DUT ----------------
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0, cmd_sel = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic        wr_valid = 1'b0, wr_ready, rd_valid, done;
    logic [1:0]  status;

    wb_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .TIMEOUT(8)) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .status(status),
        .wb(bus)
    );

    // Slave model: ACK after ack_delay waiting cycles; optional ERR at a chosen beat.
    logic        ackq = 1'b0, errq = 1'b0;
    logic        ack_en = 1'b1, err_on = 1'b0;
    int          ack_delay = 0, scnt = 0, err_at = 0, ack_total = 0;
    logic [31:0] rd_base = '0;
    logic [31:0] log_addr [0:255];
    logic [31:0] log_dat  [0:255];
    logic        log_we   [0:255];
    logic [31:0] rv_log   [0:255];
    int          stb_total = 0, stb_rises = 0, cyc_rises = 0, done_total = 0, rv_total = 0;
    logic [1:0]  last_status = '0;
    logic        stb_q = 1'b0, cyc_q = 1'b0;

    assign bus.DAT_I = rd_base ^ 32'(ack_total);
    assign bus.ACK_I = ackq;
`ifdef WB_BURST_MASTER_ERR_EN
    assign bus.ERR_I = errq;
`endif

    always @(posedge clk) begin
        stb_q <= bus.STB_O;
        cyc_q <= bus.CYC_O;
        if (bus.STB_O) stb_total <= stb_total + 1;
        if (bus.STB_O && !stb_q) stb_rises <= stb_rises + 1;
        if (bus.CYC_O && !cyc_q) cyc_rises <= cyc_rises + 1;
        if (done) begin
            done_total  <= done_total + 1;
            last_status <= status;
        end
        if (rd_valid) begin
            rv_log[rv_total % 256] <= rd_data;
            rv_total <= rv_total + 1;
        end
        if (bus.STB_O && ackq) begin
            log_addr[ack_total % 256] <= bus.ADR_O;
            log_dat[ack_total % 256]  <= bus.DAT_O;
            log_we[ack_total % 256]   <= bus.WE_O;
            ack_total <= ack_total + 1;
        end
        if (!bus.STB_O || ackq || errq) begin
            ackq <= 1'b0;
            errq <= 1'b0;
            scnt <= 0;
        end else if (ack_en) begin
            if (scnt == ack_delay) begin
                if (err_on && ack_total == err_at) errq <= 1'b1;
                else ackq <= 1'b1;
                scnt <= 0;
            end else begin
                scnt <= scnt + 1;
            end
        end
    end

    // ---------------- 8-bit address DUT ----------------
    logic        c8_valid = 1'b0, c8_ready;
    logic [7:0]  c8_addr = '0;
    logic [3:0]  c8_len = '0;
    logic [31:0] rd8_data;
    logic        wr8_ready, rd8_valid, done8;
    logic [1:0]  status8;

    wb_burst_master_if #(.ADDR_W(8), .DATA_W(32)) bus8 ();

    wb_burst_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(4), .TIMEOUT(8)) dut8 (
        .CLK_I(clk), .RST_I(rst_n),
        .cmd_valid(c8_valid), .cmd_ready(c8_ready), .cmd_we(1'b0),
        .cmd_addr(c8_addr), .cmd_len(c8_len), .cmd_sel(4'hF),
        .wr_data(32'h0), .wr_valid(1'b0), .wr_ready(wr8_ready),
        .rd_data(rd8_data), .rd_valid(rd8_valid), .done(done8), .status(status8),
        .wb(bus8)
    );

    logic       ack8 = 1'b0;
    int         a8_total = 0, done8_total = 0;
    logic [7:0] a8_log [0:3];
    logic [1:0] status8_q = '0;

    assign bus8.DAT_I = 32'hC0DE0000 | 32'(a8_total);
    assign bus8.ACK_I = ack8;
`ifdef WB_BURST_MASTER_ERR_EN
    assign bus8.ERR_I = 1'b0;
`endif

    always @(posedge clk) begin
        ack8 <= bus8.STB_O && !ack8;
        if (bus8.STB_O && ack8) begin
            a8_log[a8_total % 4] <= bus8.ADR_O;
            a8_total <= a8_total + 1;
        end
        if (done8) begin
            done8_total <= done8_total + 1;
            status8_q   <= status8;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] sel);
        @(negedge clk);
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check_eq("cmd_ready_before_issue", cmd_ready, 1);
        cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] data, input int pre);
        @(negedge clk);
        for (int i = 0; i < 100 && !wr_ready; i++) @(negedge clk);
        check_eq("wr_ready_wait", wr_ready, 1);
        repeat (pre) @(negedge clk);
        wr_data = data;
        wr_valid = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 200 && done_total == d0; i++) @(negedge clk);
        check_eq(tag, 64'(done_total - d0), 1);
    endtask

    // ---------------- test sequence ----------------
    int s, d, r, st, sr, cr;

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_cyc", bus.CYC_O, 0);
        check_eq("rst_stb", bus.STB_O, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_status", status, 0);
        check_eq("rst_wr_ready", wr_ready, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        rst_n = 1'b1;

        // single read, ACK two cycles after STB
        ack_delay = 1;
        s = ack_total; d = done_total; r = rv_total; st = stb_total;
        rd_base = 32'hDEADBEEF ^ 32'(s);
        issue(1'b0, 32'h100, 4'd0, 4'hF);
        wait_done("rd1_done", d);
        check_eq("rd1_cyc_low", bus.CYC_O, 0);
        check_eq("rd1_cmd_ready", cmd_ready, 1);
        check_eq("rd1_status", last_status, 0);
        check_eq("rd1_rv_count", 64'(rv_total - r), 1);
        check_eq("rd1_data", rv_log[r % 256], 32'hDEADBEEF);
        check_eq("rd1_addr", log_addr[s % 256], 32'h100);
        check_eq("rd1_stb_cycles", 64'(stb_total - st), 3);

        // 4-beat write burst with a stalled third beat
        ack_delay = 0;
        s = ack_total; d = done_total; sr = stb_rises; cr = cyc_rises;
        issue(1'b1, 32'h200, 4'd3, 4'hF);
        for (int k = 0; k < 4; k++) feed(32'hA0000000 + 32'(k), (k == 2) ? 3 : 0);
        wait_done("wr_done", d);
        check_eq("wr_acks", 64'(ack_total - s), 4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("wr_addr%0d", k), log_addr[(s + k) % 256], 32'h200 + 32'(4 * k));
            check_eq($sformatf("wr_data%0d", k), log_dat[(s + k) % 256], 32'hA0000000 + 32'(k));
            check_eq($sformatf("wr_we%0d", k), log_we[(s + k) % 256], 1);
        end
        check_eq("wr_stb_strobes", 64'(stb_rises - sr), 4);
        check_eq("wr_cyc_continuous", 64'(cyc_rises - cr), 1);
        check_eq("wr_status", last_status, 0);

        // timeout: slave silent
        ack_en = 1'b0;
        d = done_total; r = rv_total; st = stb_total;
        issue(1'b0, 32'h300, 4'd2, 4'hF);
        wait_done("to_done", d);
        check_eq("to_stb_cycles", 64'(stb_total - st), 8);
        check_eq("to_status", last_status, 1);
        check_eq("to_cyc_low", bus.CYC_O, 0);
        check_eq("to_cmd_ready", cmd_ready, 1);
        check_eq("to_no_rd", 64'(rv_total - r), 0);
        ack_en = 1'b1;

        // address wrap on the 8-bit DUT
        s = a8_total; d = done8_total;
        @(negedge clk);
        c8_addr = 8'hFC; c8_len = 4'd1; c8_valid = 1'b1;
        @(posedge clk);
        #1 c8_valid = 1'b0;
        for (int i = 0; i < 100 && done8_total == d; i++) @(negedge clk);
        check_eq("wrap_done", 64'(done8_total - d), 1);
        check_eq("wrap_beats", 64'(a8_total - s), 2);
        check_eq("wrap_addr0", a8_log[s % 4], 8'hFC);
        check_eq("wrap_addr1", a8_log[(s + 1) % 4], 8'h00);
        check_eq("wrap_status", status8_q, 0);
        check_eq("wrap_rd_last", rd8_data, 32'hC0DE0000 | 32'(s + 1));

        // reset during beat 2 of a 4-beat read
        s = ack_total; d = done_total;
        rd_base = 32'h5A5A0000;
        issue(1'b0, 32'h400, 4'd3, 4'hF);
        for (int i = 0; i < 100 && (ack_total - s) < 2; i++) @(negedge clk);
        check_eq("rst_mid_reached_beat2", 64'(ack_total - s), 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cyc", bus.CYC_O, 0);
        check_eq("rst_mid_stb", bus.STB_O, 0);
        check_eq("rst_mid_cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_done", 64'(done_total - d), 0);
        rst_n = 1'b1;
        s = ack_total; d = done_total; r = rv_total;
        rd_base = 32'h12345678 ^ 32'(s);
        issue(1'b0, 32'h500, 4'd0, 4'hF);
        wait_done("post_rst_done", d);
        check_eq("post_rst_status", last_status, 0);
        check_eq("post_rst_data", rv_log[r % 256], 32'h12345678);
        check_eq("post_rst_addr", log_addr[s % 256], 32'h500);

`ifdef WB_BURST_MASTER_ERR_EN
        // bus error on beat 1 of a 3-beat read
        s = ack_total; d = done_total; r = rv_total;
        rd_base = 32'h0BADF00D ^ 32'(s);
        err_at = s + 1; err_on = 1'b1;
        issue(1'b0, 32'h600, 4'd2, 4'hF);
        wait_done("err_done", d);
        err_on = 1'b0;
        check_eq("err_status", last_status, 2);
        check_eq("err_rv_count", 64'(rv_total - r), 1);
        check_eq("err_rv_data", rv_log[r % 256], 32'h0BADF00D);
        check_eq("err_cyc_low", bus.CYC_O, 0);
        check_eq("err_acks", 64'(ack_total - s), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
